// File: rtl/puf_ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module     : puf_ecc_pkg
// Description: Shared Hamming(15,11) constants for the PUF helper-data
//              encoder and decoder: code dimensions, FSM states, parity masks.
// Revision   : 1.0 - initial release
// ============================================================================
package puf_ecc_pkg;

    localparam int K        = 11;   // data bits per word
    localparam int R        = 4;    // parity bits per word
    localparam int N_CHUNKS = 24;   // words per PUF response

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Mask bit i (left = d0) selects the data bits covered by parity p[j].
    // The decoder syndrome logic reuses these exact masks.
    localparam logic [0:K-1] PARITY_MASK [0:R-1] = '{
        11'b11011010101,    // p0 = d0^d1^d3^d4^d6^d8^d10
        11'b10110110011,    // p1 = d0^d2^d3^d5^d6^d9^d10
        11'b01110001111,    // p2 = d1^d2^d3^d7^d8^d9^d10
        11'b00001111111     // p3 = d4^d5^d6^d7^d8^d9^d10
    };

endpackage
`default_nettype wire

// File: rtl/hamming_15_11_parity.sv
`default_nettype none
// ============================================================================
// Module     : hamming_15_11_parity
// Description: Combinational even-parity generator, d[0:10] -> p[0:3].
// Revision   : 1.0 - initial release
// ============================================================================
module hamming_15_11_parity
    import puf_ecc_pkg::*;
(
    input  logic [0:K-1] d,
    output logic [0:R-1] p
);

    // Each parity bit is the XOR reduction of the data bits its mask covers.
    for (genvar i = 0; i < R; i++) begin : g_parity
        assign p[i] = ^(d & PARITY_MASK[i]);
    end

endmodule
`default_nettype wire

// File: rtl/hamming_helper_encoder.sv
`default_nettype none
// ============================================================================
// Module     : hamming_helper_encoder
// Description: Enrollment-side helper-data generator. Captures a PUF
//              response and produces 4 Hamming(15,11) parity bits per
//              11-bit chunk, one chunk per clock.
// Revision   : 1.0 - initial release
// ============================================================================
module hamming_helper_encoder #(
    parameter int N_CHUNKS = puf_ecc_pkg::N_CHUNKS,
    parameter int K        = puf_ecc_pkg::K,
    parameter int R        = puf_ecc_pkg::R
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [0:K*N_CHUNKS-1] i_data,
    output logic                  busy,
    output logic                  done,
    output logic [0:R*N_CHUNKS-1] o_helper
);

    import puf_ecc_pkg::*;

    localparam int             CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(N_CHUNKS - 1);

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [0:K*N_CHUNKS-1]   data_q;
    logic [0:K-1]            chunk;
    logic [0:R-1]            parity;

    // The single parity generator is time-multiplexed across chunks by cnt.
    assign chunk = data_q[K*int'(cnt) +: K];

    hamming_15_11_parity u_parity (
        .d (chunk),
        .p (parity)
    );

    // Control FSM with registered busy/done; writes one helper chunk per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            o_helper <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        data_q <= i_data;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    o_helper[R*int'(cnt) +: R] <= parity;
                    if (cnt == CNT_LAST) begin
                        // Park the counter at zero so it never leaves 0..N_CHUNKS-1.
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_helper_encoder.sv
`default_nettype none
// ============================================================================
// Module     : tb_hamming_helper_encoder
// Description: Self-checking bench for hamming_helper_encoder with a
//              behavioural reference model based on Hamming code positions.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_hamming_helper_encoder;

    localparam int N  = 24;
    localparam int K  = 11;
    localparam int R  = 4;
    localparam int DW = K * N;
    localparam int HW = R * N;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [0:DW-1]   i_data = '0;
    logic            busy;
    logic            done;
    logic [0:HW-1]   o_helper;

    int tests = 0;
    int fails = 0;

    hamming_helper_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .i_data   (i_data),
        .busy     (busy),
        .done     (done),
        .o_helper (o_helper)
    );

    always #5 clk = ~clk;

    // Data bit d[i] sits at Hamming code position DPOS[i]; parity p[j] is at
    // position 2^j and covers every position whose bit j is set.
    function automatic logic [0:3] ref_chunk(input logic [0:10] d);
        int dpos [0:10] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [0:3] p = '0;
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 11; i++)
                if (((dpos[i] >> j) & 1) == 1) p[j] = p[j] ^ d[i];
        return p;
    endfunction

    function automatic logic [0:HW-1] ref_helper(input logic [0:DW-1] d);
        logic [0:HW-1] h = '0;
        for (int k = 0; k < N; k++) h[4*k +: 4] = ref_chunk(d[11*k +: 11]);
        return h;
    endfunction

    task automatic chk(input string name, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0 = idle, 1..N = writing chunk phase-1, N+1 = done cycle.
    int            m_phase = 0;
    logic [0:DW-1] m_data = '0;
    logic [0:HW-1] m_helper = '0;
    bit            check_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase  = 0;
            m_helper = '0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_data  = i_data;
                m_phase = 1;
            end
        end else if (m_phase <= N) begin
            m_helper[4*(m_phase-1) +: 4] = ref_chunk(m_data[11*(m_phase-1) +: 11]);
            m_phase++;
        end else begin
            m_phase = 0;
        end
        check_en = 1;
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", HW'(busy), HW'(m_phase >= 1 && m_phase <= N));
            chk("done", HW'(done), HW'(m_phase == N + 1));
            chk("helper", o_helper, m_helper);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [0:DW-1] rand_data();
        logic [0:DW-1] d = '0;
        for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
        return d;
    endfunction

    // Pulse start with data d; report posedges from the accepting edge to done.
    task automatic run_wait(input logic [0:DW-1] d, output int lat);
        bit seen = 0;
        @(negedge clk);
        i_data = d;
        start  = 1'b1;
        lat    = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL timeout: done not seen within 40 cycles");
        end
    endtask

    // Flip one bit per chunk of {data,helper}, decode by syndrome, compare.
    task automatic check_correction(input logic [0:DW-1] d, input logic [0:HW-1] h);
        for (int k = 0; k < N; k++) begin
            logic code [1:15];
            int dpos [0:10] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
            int syn = 0;
            int f;
            logic [0:10] rec;
            for (int j = 0; j < 4; j++) code[1 << j] = h[4*k + j];
            for (int i = 0; i < 11; i++) code[dpos[i]] = d[11*k + i];
            f = $urandom_range(1, 15);
            code[f] = ~code[f];
            for (int p = 1; p <= 15; p++) if (code[p]) syn = syn ^ p;
            if (syn != 0) code[syn] = ~code[syn];
            for (int i = 0; i < 11; i++) rec[i] = code[dpos[i]];
            chk("correct", HW'(rec), HW'(d[11*k +: 11]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        logic [0:DW-1] d, d2;
        logic [0:HW-1] exp;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_helper", o_helper, '0);
        chk("reset_busy", HW'(busy), '0);

        // All-zero response: zero helper, 25-cycle latency.
        run_wait('0, lat);
        chk("zero_helper", o_helper, '0);
        chk("zero_latency", HW'(lat), HW'(25));

        // All-ones response: every chunk parity is 1111.
        d = '1;
        run_wait(d, lat);
        exp = '1;
        chk("ones_helper", o_helper, exp);

        // Single bit in chunk 0, d0.
        d = '0; d[0] = 1'b1;
        run_wait(d, lat);
        exp = '0; exp[0:3] = 4'b1100;
        chk("chunk0_d0", o_helper, exp);

        // Single bit in chunk 23, d4.
        d = '0; d[257] = 1'b1;
        run_wait(d, lat);
        exp = '0; exp[92:95] = 4'b1001;
        chk("chunk23_d4", o_helper, exp);

        // Random responses with single-error correction round trip.
        for (int t = 0; t < 4; t++) begin
            d = rand_data();
            run_wait(d, lat);
            chk("rand_helper", o_helper, ref_helper(d));
            chk("rand_latency", HW'(lat), HW'(25));
            check_correction(d, o_helper);
        end

        // Re-pulsed start with new data during RUN is ignored.
        d  = rand_data();
        d2 = ~d;
        @(negedge clk);
        i_data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        i_data = d2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            bit seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            tests++;
            if (!seen) begin fails++; $display("FAIL timeout: repulse done not seen"); end
        end
        chk("repulse_helper", o_helper, ref_helper(d));
        repeat (3) @(negedge clk);
        chk("repulse_single_done", HW'(busy | done), '0);

        // Reset mid-RUN aborts with cleared outputs, then a clean run.
        d = rand_data();
        @(negedge clk);
        i_data = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_helper", o_helper, '0);
        chk("abort_busy_done", HW'({busy, done}), '0);
        d = rand_data();
        run_wait(d, lat);
        chk("after_abort_helper", o_helper, ref_helper(d));
        chk("after_abort_latency", HW'(lat), HW'(25));

        // Start held high re-triggers on return to IDLE.
        d = rand_data();
        @(negedge clk);
        i_data = d; start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_start_helper", o_helper, ref_helper(d));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
